feature_deserializer: RTL and testbench

- Input-side counterpart of the conv output post-processing reduction.
- Takes a narrow, pin-limited stream of signed feature words, one per accepted beat.
- Assembles FEATURES_DEPTH consecutive words into one parallel feature vector for the conv layer input.
- Valid/ready on both sides; full throughput (one vector per FEATURES_DEPTH accepted beats) when the consumer does not stall.

---
 rtl/feature_deserializer.sv | 145 ++++++++++++++
 tb/tb_feature_deserializer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/feature_deserializer.sv
// feature_deserializer: collects FEATURES_DEPTH serial signed words into one
// parallel feature vector with valid/ready handshakes on both sides.
// Lane 0 of the vector holds the first word received.

// One assembly-buffer lane: a register that loads the incoming word when
// this lane is addressed.
module feature_lane #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] q
);
  logic [W-1:0] q_d, q_q;

  // next-state: load on write enable, otherwise hold
  always_comb begin
    q_d = q_q;
    if (we) q_d = wdata;
  end

  // lane register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;
endmodule

module feature_deserializer #(
  parameter int unsigned FEATURE_WIDTH  = 16,
  parameter int unsigned FEATURES_DEPTH = 6
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  input  logic                                                   in_sof,
  input  logic signed [FEATURE_WIDTH-1:0]                        in_data,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic signed [FEATURES_DEPTH-1:0][FEATURE_WIDTH-1:0]    out_features,
  output logic                                                   sync_error
);
  localparam int unsigned CW = $clog2(FEATURES_DEPTH + 1);
  localparam logic [CW-1:0] LAST = CW'(FEATURES_DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(FEATURES_DEPTH);

  logic [CW-1:0]                                  cnt_q, cnt_d;
  logic                                           out_valid_q, out_valid_d;
  logic                                           sync_error_q, sync_error_d;
  logic [FEATURES_DEPTH-1:0][FEATURE_WIDTH-1:0]   lane_q;
  logic [FEATURES_DEPTH-1:0][FEATURE_WIDTH-1:0]   out_q, out_d;
  logic [FEATURES_DEPTH-1:0]                      lane_we;
  logic                                           accept, out_free;
  logic                                           load_out, last_from_in;

  // in_ready is a pure decode of registered state so no combinational path
  // exists from out_ready or in_valid.
  assign in_ready = rst_n && (cnt_q < FULL);
  assign accept   = in_valid && in_ready;
  // The holding register can take a new vector if empty or draining now.
  assign out_free = !out_valid_q || out_ready;

  for (genvar g = 0; g < FEATURES_DEPTH; g++) begin : g_lane
    feature_lane #(.W(FEATURE_WIDTH)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (lane_we[g]),
      .wdata (in_data),
      .q     (lane_q[g])
    );
  end

  // lane counter, lane write enables, output load and sync tracking
  always_comb begin
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q && !out_ready;
    sync_error_d = sync_error_q;
    lane_we      = '0;
    load_out     = 1'b0;
    last_from_in = 1'b0;
    if (cnt_q == FULL) begin
      // stalled full buffer waits for the holding register to free up
      if (out_free) begin
        load_out    = 1'b1;
        out_valid_d = 1'b1;
        cnt_d       = '0;
      end
    end else if (accept) begin
      if (in_sof && (cnt_q != '0)) begin
        // resync: drop the partial vector, this word becomes lane 0
        lane_we[0]   = 1'b1;
        cnt_d        = CW'(1);
        sync_error_d = 1'b1;
      end else if (cnt_q == LAST) begin
        if (out_free) begin
          // last word bypasses the buffer straight into the output
          load_out     = 1'b1;
          last_from_in = 1'b1;
          out_valid_d  = 1'b1;
          cnt_d        = '0;
        end else begin
          lane_we[FEATURES_DEPTH-1] = 1'b1;
          cnt_d                     = FULL;
        end
      end else begin
        for (int i = 0; i < FEATURES_DEPTH - 1; i++)
          if (cnt_q == CW'(i)) lane_we[i] = 1'b1;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // holding-register next value: buffer lanes, last lane optionally from input
  always_comb begin
    out_d = out_q;
    if (load_out) begin
      out_d = lane_q;
      if (last_from_in) out_d[FEATURES_DEPTH-1] = in_data;
    end
  end

  // control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      sync_error_q <= 1'b0;
      out_q        <= '0;
    end else begin
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      sync_error_q <= sync_error_d;
      out_q        <= out_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_features = out_q;
  assign sync_error   = sync_error_q;
endmodule

// File: tb/tb_feature_deserializer.sv
// Directed bench for feature_deserializer: expected vectors are queued by
// the stimulus and checked by an independent monitor on each output transfer.
module tb_feature_deserializer;
  localparam int W = 16;
  localparam int D = 6;
  typedef logic [D-1:0][W-1:0] vec_t;

  logic clk, rst_n, in_valid, in_ready, in_sof, out_valid, out_ready, sync_error;
  logic signed [W-1:0] in_data;
  logic signed [D-1:0][W-1:0] out_features;

  int n_cmp = 0, n_err = 0, cyc = 0;
  vec_t exp_q[$];

  feature_deserializer #(.FEATURE_WIDTH(W), .FEATURES_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sof(in_sof), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_features(out_features), .sync_error(sync_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input int a, input int b, input int c,
                              input int d, input int e, input int f);
    vec_t v;
    v[0] = W'(a); v[1] = W'(b); v[2] = W'(c);
    v[3] = W'(d); v[4] = W'(e); v[5] = W'(f);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: every output transfer must match the oldest queued vector
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL vec_unexpected: got %h expected none", out_features);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        if (out_features !== e) begin
          n_err++;
          $display("FAIL vec: got %h expected %h", out_features, e);
        end
      end
    end
  end

  // drive one beat and hold it until accepted (bounded)
  task automatic beat(input int d, input bit sof);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = W'(d); in_sof = sof;
    forever begin
      @(negedge clk);
      if (in_ready) begin @(posedge clk); #1; break; end
      n++;
      if (n > 50) begin
        n_cmp++; n_err++;
        $display("FAIL beat_timeout: got in_ready 0 expected 1 within 50 cycles");
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
  endtask

  int s2[18] = '{-1, 100, -32768, 32767, 0, 1, -2, -100, 12345, -12345, 255,
                 -256, 21845, -21846, 7, -7, 16384, -16385};

  initial begin
    int c0, w;
    vec_t v;
    rst_n = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 96'(out_valid), 96'(0));
    chk("rst_in_ready", 96'(in_ready), 96'(0));
    chk("rst_sync", 96'(sync_error), 96'(0));
    chk("rst_features", 96'(out_features), 96'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: six back-to-back beats, one-cycle latency, no stalls
    out_ready = 1'b1;
    exp_q.push_back(mk(1, 2, 3, 4, 5, 6));
    c0 = cyc;
    for (int i = 1; i <= 6; i++) beat(i, 1'b0);
    idle();
    chk("t1_cycles", 96'(cyc - c0), 96'(6));
    chk("t1_valid", 96'(out_valid), 96'(1));
    chk("t1_data", 96'(out_features), 96'(mk(1, 2, 3, 4, 5, 6)));
    @(posedge clk); #1;
    chk("t1_pulse", 96'(out_valid), 96'(0));

    // 2: 18 continuous signed beats -> 3 vectors
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < D; j++) v[j] = W'(s2[k*D+j]);
      exp_q.push_back(v);
    end
    c0 = cyc;
    for (int i = 0; i < 18; i++) beat(s2[i], 1'b0);
    idle();
    chk("t2_cycles", 96'(cyc - c0), 96'(18));
    @(posedge clk); #1;

    // 3: consumer stalled for 12 beats, then a single-cycle drain
    out_ready = 1'b0;
    exp_q.push_back(mk(31, 32, 33, 34, 35, 36));
    exp_q.push_back(mk(41, 42, 43, 44, 45, 46));
    for (int i = 31; i <= 36; i++) beat(i, 1'b0);
    for (int i = 41; i <= 46; i++) beat(i, 1'b0);
    idle();
    chk("t3_in_ready_full", 96'(in_ready), 96'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("t3_hold_valid", 96'(out_valid), 96'(1));
    chk("t3_hold_data", 96'(out_features), 96'(mk(31, 32, 33, 34, 35, 36)));
    chk("t3_in_ready_held", 96'(in_ready), 96'(0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("t3_v2_valid", 96'(out_valid), 96'(1));
    chk("t3_v2_data", 96'(out_features), 96'(mk(41, 42, 43, 44, 45, 46)));
    chk("t3_in_ready_back", 96'(in_ready), 96'(1));
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_drained", 96'(out_valid), 96'(0));

    // 4: in_sof on the first beat of each vector is not an error
    exp_q.push_back(mk(-5, 6, -7, 8, -9, 10));
    exp_q.push_back(mk(50, 51, 52, 53, 54, 55));
    beat(-5, 1'b1); beat(6, 1'b0); beat(-7, 1'b0); beat(8, 1'b0); beat(-9, 1'b0); beat(10, 1'b0);
    for (int i = 50; i <= 55; i++) beat(i, i == 50);
    idle();
    @(posedge clk); #1;
    chk("t4_sync_clean", 96'(sync_error), 96'(0));

    // 5: in_sof after a 3-word partial resyncs and flags sync_error
    exp_q.push_back(mk(20, 21, 22, 23, 24, 25));
    beat(10, 1'b0); beat(11, 1'b0); beat(12, 1'b0);
    for (int i = 20; i <= 25; i++) beat(i, i == 20);
    idle();
    chk("t5_sync_set", 96'(sync_error), 96'(1));
    exp_q.push_back(mk(60, 61, 62, 63, 64, 65));
    for (int i = 60; i <= 65; i++) beat(i, i == 60);
    idle();
    @(posedge clk); #1;
    chk("t5_sync_sticky", 96'(sync_error), 96'(1));

    // 6: async reset with out_valid=1 and a 4-word partial pending
    out_ready = 1'b0;
    for (int i = 70; i <= 75; i++) beat(i, 1'b0);
    for (int i = 80; i <= 83; i++) beat(i, 1'b0);
    idle();
    chk("t6_pre_valid", 96'(out_valid), 96'(1));
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 96'(out_valid), 96'(0));
    chk("t6_rst_features", 96'(out_features), 96'(0));
    chk("t6_rst_in_ready", 96'(in_ready), 96'(0));
    chk("t6_rst_sync", 96'(sync_error), 96'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(mk(90, -91, 92, -93, 94, -95));
    beat(90, 1'b0); beat(-91, 1'b0); beat(92, 1'b0); beat(-93, 1'b0); beat(94, 1'b0); beat(-95, 1'b0);
    idle();

    w = 0;
    while (exp_q.size() != 0 && w < 20) begin @(posedge clk); #1; w++; end
    chk("queue_empty", 96'(exp_q.size()), 96'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
